hdmi_capture_packer: RTL

- Capture-side gearbox: packs a free-running 24-bit RGB pixel stream, one pixel per valid cycle, into 64-bit AXI4-Stream words for the capture DMA.
- Exact inverse of the playback unpacker: 8 pixels map onto 3 words.
- Frame boundaries come from sof/eof. The final word of each frame carries tlast.
- A word FIFO absorbs DMA backpressure, because the pixel source cannot be stalled.

---
 rtl/hdmi_capture_packer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/hdmi_capture_packer.sv
// rtl/hdmi_capture_packer.sv - packs 24-bit RGB pixels into 64-bit AXI-Stream words via a word FIFO
module hdmi_capture_packer #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [23:0] pixel_data,
  input  logic        pixel_valid,
  input  logic        sof,
  input  logic        eof,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        overflow,
  output logic        resync
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_e;

  state_e      state_q, state_d;
  logic [2:0]  count_q, count_d;
  logic [55:0] acc_q, acc_d;
  logic        stage_valid_q, stage_valid_d;
  logic [63:0] stage_data_q, stage_data_d;
  logic        stage_last_q, stage_last_d;
  logic        overflow_q, overflow_d;
  logic        resync_q, resync_d;

  logic [64:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] fill;
  logic        fifo_empty, fifo_full, push, pop, drop;

  logic [2:0]  base_count;
  logic [55:0] base_acc;
  logic [3:0]  sum;
  logic [79:0] merged;
  logic        accept;

  assign fill       = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fill == '0);
  assign fifo_full  = (fill == {1'b1, {AW{1'b0}}});
  assign pop        = !fifo_empty && m_axis_tready;
  assign push       = stage_valid_q && (!fifo_full || pop);
  assign drop       = stage_valid_q && fifo_full && !pop;

  // A sof pixel always restarts packing from byte offset 0, discarding any residual.
  always_comb begin
    base_count = count_q;
    base_acc   = acc_q;
    if (sof) begin
      base_count = 3'd0;
      base_acc   = 56'd0;
    end
    sum    = {1'b0, base_count} + 4'd3;
    merged = {24'd0, base_acc} | ({56'd0, pixel_data} << {base_count, 3'b000});
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    acc_d         = acc_q;
    stage_valid_d = 1'b0;
    stage_data_d  = stage_data_q;
    stage_last_d  = 1'b0;
    overflow_d    = drop;
    resync_d      = 1'b0;
    accept        = 1'b0;

    case (state_q)
      ST_IDLE: accept = pixel_valid && sof;
      ST_RUN: begin
        accept   = pixel_valid;
        resync_d = pixel_valid && sof;
      end
      ST_FLUSH: begin
        stage_valid_d = 1'b1;
        stage_data_d  = {8'd0, acc_q};
        stage_last_d  = 1'b1;
        count_d       = 3'd0;
        acc_d         = 56'd0;
        state_d       = ST_IDLE;
        resync_d      = pixel_valid;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      if (sum[3]) begin
        stage_valid_d = 1'b1;
        stage_data_d  = merged[63:0];
        acc_d         = {40'd0, merged[79:64]};
      end else begin
        acc_d = merged[55:0];
      end
      count_d = sum[2:0];
      state_d = ST_RUN;
      if (eof) begin
        if (sum[2:0] == 3'd0) begin
          stage_last_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_FLUSH;
        end
      end
    end

    // A dropped word aborts the frame; nothing more is packed until the next sof.
    if (drop) begin
      state_d       = ST_IDLE;
      count_d       = 3'd0;
      acc_d         = 56'd0;
      stage_valid_d = 1'b0;
      stage_last_d  = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= ST_IDLE;
      count_q       <= 3'd0;
      acc_q         <= 56'd0;
      stage_valid_q <= 1'b0;
      stage_data_q  <= 64'd0;
      stage_last_q  <= 1'b0;
      overflow_q    <= 1'b0;
      resync_q      <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      acc_q         <= acc_d;
      stage_valid_q <= stage_valid_d;
      stage_data_q  <= stage_data_d;
      stage_last_q  <= stage_last_d;
      overflow_q    <= overflow_d;
      resync_q      <= resync_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {stage_last_q, stage_data_q};
  end

  assign m_axis_tvalid = !fifo_empty;
  assign {m_axis_tlast, m_axis_tdata} = fifo_empty ? 65'd0 : mem_q[rd_ptr_q[AW-1:0]];
  assign overflow = overflow_q;
  assign resync   = resync_q;

endmodule
